// File: rtl/i2s_tx_10xe_axi4_lite_regs.sv
// AXI4-Lite control/status register file for the I2S transmitter core.
// Optional macro I2S_TX_10XE_AXI4_LITE_SLVERR_EN: unmapped accesses answer SLVERR instead of OKAY.
module i2s_tx_10xe_axi4_lite_regs #(
    parameter logic [31:0] VERSION     = 32'h0001_0000,
    parameter logic [7:0]  CLK_DIV_RST = 8'd4
) (
    input  logic        s_axi_ctrl_aclk,
    input  logic        s_axi_ctrl_areset,
    input  logic        s_axi_ctrl_awvalid,
    output logic        s_axi_ctrl_awready,
    input  logic [7:0]  s_axi_ctrl_awaddr,
    input  logic        s_axi_ctrl_wvalid,
    output logic        s_axi_ctrl_wready,
    input  logic [31:0] s_axi_ctrl_wdata,
    output logic        s_axi_ctrl_bvalid,
    input  logic        s_axi_ctrl_bready,
    output logic [1:0]  s_axi_ctrl_bresp,
    input  logic        s_axi_ctrl_arvalid,
    output logic        s_axi_ctrl_arready,
    input  logic [7:0]  s_axi_ctrl_araddr,
    output logic        s_axi_ctrl_rvalid,
    input  logic        s_axi_ctrl_rready,
    output logic [31:0] s_axi_ctrl_rdata,
    output logic [1:0]  s_axi_ctrl_rresp,
    output logic        core_en_o,
    output logic [7:0]  clk_div_o,
    output logic        irq_o,
    input  logic        underflow_i,
    input  logic        tx_busy_i
);

    // Word indices (byte address >> 2)
    localparam logic [5:0] A_VERSION = 6'h00;
    localparam logic [5:0] A_CTRL    = 6'h02;
    localparam logic [5:0] A_STATUS  = 6'h03;
    localparam logic [5:0] A_INT     = 6'h04;
    localparam logic [5:0] A_ERR     = 6'h05;
    localparam logic [5:0] A_DIV     = 6'h08;
`ifdef I2S_TX_10XE_AXI4_LITE_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    logic        awready_q, awready_d, wready_q, wready_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [5:0]  awaddr_q, awaddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        core_en_q, core_en_d, int_en_q, int_en_d;
    logic        err_q, err_d, irq_q, irq_d;
    logic [7:0]  clk_div_q, clk_div_d;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic        wr_mapped, rd_mapped;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_ctrl_awaddr[1:0], s_axi_ctrl_araddr[1:0], s_axi_ctrl_wdata[31:8]};

    function automatic logic is_mapped(input logic [5:0] a);
        case (a)
            A_VERSION, A_CTRL, A_STATUS, A_INT, A_ERR, A_DIV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        rd_word = 32'h0;
        case (s_axi_ctrl_araddr[7:2])
            A_VERSION: rd_word = VERSION;
            A_CTRL:    rd_word[0] = core_en_q;
            A_STATUS:  rd_word[0] = tx_busy_i;
            A_INT:     rd_word[0] = int_en_q;
            A_ERR:     rd_word[0] = err_q;
            A_DIV:     rd_word[7:0] = clk_div_q;
            default:   rd_word = 32'h0;
        endcase
    end

    always_comb begin
        aw_hs     = s_axi_ctrl_awvalid & awready_q;
        w_hs      = s_axi_ctrl_wvalid & wready_q;
        b_hs      = bvalid_q & s_axi_ctrl_bready;
        ar_hs     = s_axi_ctrl_arvalid & arready_q;
        r_hs      = rvalid_q & s_axi_ctrl_rready;
        commit    = aw_held_q & w_held_q;
        wr_mapped = is_mapped(awaddr_q);
        rd_mapped = is_mapped(s_axi_ctrl_araddr[7:2]);

        awready_d = awready_q;  wready_d  = wready_q;
        aw_held_d = aw_held_q;  w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;   wdata_d   = wdata_q;
        bvalid_d  = bvalid_q;   bresp_d   = bresp_q;
        arready_d = arready_q;  rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;    rresp_d   = rresp_q;
        core_en_d = core_en_q;  int_en_d  = int_en_q;
        clk_div_d = clk_div_q;  err_d     = err_q;
        irq_d     = err_q & int_en_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awready_d = 1'b0;
            awaddr_d  = s_axi_ctrl_awaddr[7:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wready_d = 1'b0;
            wdata_d  = s_axi_ctrl_wdata[7:0];
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_mapped ? 2'b00 : RESP_UNMAPPED;
            case (awaddr_q)
                A_CTRL:  core_en_d = wdata_q[0];
                A_INT:   int_en_d  = wdata_q[0];
                A_ERR:   if (wdata_q[0]) err_d = 1'b0;
                A_DIV:   clk_div_d = wdata_q;
                default: ;
            endcase
        end
        // Ready lines come back only once the response has been taken
        if (b_hs) begin
            bvalid_d  = 1'b0;
            bresp_d   = 2'b00;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
        if (underflow_i) err_d = 1'b1;

        if (ar_hs) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = rd_word;
            rresp_d   = rd_mapped ? 2'b00 : RESP_UNMAPPED;
        end
        if (r_hs) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
        end
    end

    always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
        if (s_axi_ctrl_areset) begin
            awready_q <= 1'b1;  wready_q  <= 1'b1;
            aw_held_q <= 1'b0;  w_held_q  <= 1'b0;
            awaddr_q  <= 6'h0;  wdata_q   <= 8'h0;
            bvalid_q  <= 1'b0;  bresp_q   <= 2'b00;
            arready_q <= 1'b1;  rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0; rresp_q   <= 2'b00;
            core_en_q <= 1'b0;  int_en_q  <= 1'b0;
            clk_div_q <= CLK_DIV_RST;
            err_q     <= 1'b0;  irq_q     <= 1'b0;
        end else begin
            awready_q <= awready_d;  wready_q  <= wready_d;
            aw_held_q <= aw_held_d;  w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;   wdata_q   <= wdata_d;
            bvalid_q  <= bvalid_d;   bresp_q   <= bresp_d;
            arready_q <= arready_d;  rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;    rresp_q   <= rresp_d;
            core_en_q <= core_en_d;  int_en_q  <= int_en_d;
            clk_div_q <= clk_div_d;
            err_q     <= err_d;      irq_q     <= irq_d;
        end
    end

    assign s_axi_ctrl_awready = awready_q;
    assign s_axi_ctrl_wready  = wready_q;
    assign s_axi_ctrl_bvalid  = bvalid_q;
    assign s_axi_ctrl_bresp   = bresp_q;
    assign s_axi_ctrl_arready = arready_q;
    assign s_axi_ctrl_rvalid  = rvalid_q;
    assign s_axi_ctrl_rdata   = rdata_q;
    assign s_axi_ctrl_rresp   = rresp_q;
    assign core_en_o          = core_en_q;
    assign clk_div_o          = clk_div_q;
    assign irq_o              = irq_q;

endmodule

// File: doc/i2s_tx_10xe_axi4_lite_regs.md
Name: i2s_tx_10xe_axi4_lite_regs

Overview:
AXI4-Lite responder (slave) holding the I2S transmitter control/status register file. Sits on the s_axi_ctrl bus opposite the AXI4-Lite initiator and terminates all five channels. Drives the configuration outputs into the I2S TX core and collects its status and error events. One outstanding write and one outstanding read at a time; the read and write paths are independent.

Parameters:
- VERSION, 32'h0001_0000, value returned by the read-only CORE_VERSION register.
- CLK_DIV_RST, 8'd4, reset value of CLK_DIV.

Ports:
- s_axi_ctrl_aclk  in  1  sole clock
- s_axi_ctrl_areset  in  1  asynchronous reset, active-high
- s_axi_ctrl_awvalid / awready  in/out  1  write-address handshake
- s_axi_ctrl_awaddr  in  8  write byte address
- s_axi_ctrl_wvalid / wready  in/out  1  write-data handshake
- s_axi_ctrl_wdata  in  32  write data
- s_axi_ctrl_bvalid / bready  out/in  1  write-response handshake
- s_axi_ctrl_bresp  out  2  write response
- s_axi_ctrl_arvalid / arready  in/out  1  read-address handshake
- s_axi_ctrl_araddr  in  8  read byte address
- s_axi_ctrl_rvalid / rready  out/in  1  read-data handshake
- s_axi_ctrl_rdata  out  32  read data
- s_axi_ctrl_rresp  out  2  read response
- core_en_o  out  1  TX core enable
- clk_div_o  out  8  SCLK divider
- irq_o  out  1  interrupt, level
- underflow_i  in  1  single-cycle underflow event from the TX core
- tx_busy_i  in  1  TX core busy status

Behaviour:
- Register map (word-aligned; awaddr/araddr[1:0] ignored):
  - 0x00 CORE_VERSION: RO = VERSION.
  - 0x08 CORE_CTRL: RW; bit0 = core_en.
  - 0x0C STATUS: RO; bit0 = tx_busy_i, sampled at the read handshake.
  - 0x10 INT_CTRL: RW; bit0 = underflow irq enable.
  - 0x14 ERR_STATUS: bit0 = underflow, sticky, write-1-to-clear.
  - 0x20 CLK_DIV: RW [7:0].
  - Unused bits read 0.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, core_en=0, INT_CTRL=0, ERR_STATUS=0, CLK_DIV=CLK_DIV_RST, irq_o=0.
- Reset mid-transaction: any pending AW, W, B or R is abandoned immediately, and all outputs return to their reset values.
- Write path:
  - AW and W are captured independently, in either order or in the same cycle.
  - awready deasserts after the AW capture; wready deasserts after the W capture.
  - The cycle after both are held: register update and bvalid=1 in that same edge, with bresp.
  - Same-cycle AW+W gives bvalid 1 cycle after the handshake.
  - bvalid and bresp hold stable until bready.
  - On the B handshake: bvalid=0, and awready and wready return to 1 on the next cycle edge. No new AW/W is accepted while bvalid=1.
- Read path:
  - On the AR handshake: arready=0, and rvalid=1 with rdata/rresp on the next edge.
  - rdata/rresp hold stable until rready.
  - On the R handshake: rvalid=0 and arready=1.
- Reads and writes in the same cycle are both serviced. A read of a register being written in that cycle returns the old value.
- ERR_STATUS:
  - underflow_i=1 sets bit0.
  - A write of 1 to bit0 clears it.
  - Simultaneous set and clear: set wins.
- irq_o = registered (ERR_STATUS[0] & INT_CTRL[0]), so it lags one cycle.
- Writes to RO registers are ignored and respond OKAY.

Optional Feature:
- Macro I2S_TX_10XE_AXI4_LITE_SLVERR_EN.
- Defined: an access to an unmapped address returns bresp/rresp = 2'b10 (SLVERR). Unmapped writes have no effect; unmapped reads return rdata=0.
- Undefined: unmapped accesses return 2'b00 (OKAY), with the same rdata=0 and no register effect.

Test Plan:
- Reset, then read 0x00 and 0x20 -> rdata 32'h0001_0000 and 32'h4, rresp 0; every output matches its reset value.
- W (0x1) presented 3 cycles before AW (0x08) -> wready drops after the W capture; bvalid rises 1 cycle after the AW capture; core_en_o=1.
- AW+W to 0x20 with data 0xAB and bready held low for 5 cycles -> bvalid/bresp stable throughout; no new AW accepted; clk_div_o=0xAB.
- INT_CTRL=1, pulse underflow_i -> ERR_STATUS=1 and irq_o=1 one cycle later. Write 1 to 0x14 in the same cycle as another underflow pulse -> bit stays 1. Clean write of 1 -> irq_o falls.
- Read 0x40 -> rdata 0 with rresp 2'b10 if SLVERR_EN is defined, else 2'b00; write 0x40 gives the same bresp and no register changes.
- Assert reset while rvalid=1 and rready=0 -> rvalid=0 immediately and registers reset; a subsequent read completes normally.
